// File: rtl/turn_if.sv
// turn_if: handshake bundle between turn_sequencer and the button, comparator and move units.
interface turn_if;
    logic       start;
    logic [1:0] num_players;
    logic       flip_req;
    logic [3:0] flip_idx;
    logic       cmp_done;
    logic       cmp_match;
    logic       move_done;
    logic       win_det;
    logic [1:0] turn;
    logic [2:0] state;
    logic       cmp_start;
    logic [3:0] cmp_idx;
    logic       move_start;
    logic       timeout;
    logic       game_over;
    logic [1:0] winner;
    modport master (
        output start, num_players, flip_req, flip_idx, cmp_done, cmp_match, move_done, win_det,
        input  turn, state, cmp_start, cmp_idx, move_start, timeout, game_over, winner
    );
    modport slave (
        input  start, num_players, flip_req, flip_idx, cmp_done, cmp_match, move_done, win_det,
        output turn, state, cmp_start, cmp_idx, move_start, timeout, game_over, winner
    );
endinterface

// File: rtl/turn_sequencer.sv
// turn_sequencer: owns the current player and sequences flip, compare, move and turn hand-over.
module turn_sequencer #(
    parameter int TURN_TIMEOUT = 500_000_000,
    parameter int TW           = 29
) (
    input logic   clk,
    input logic   rst_n,
    turn_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_FLIP = 3'd1,
        COMPARE   = 3'd2,
        MOVE      = 3'd3,
        NEXT      = 3'd4,
        OVER      = 3'd5
    } state_t;
    localparam logic [TW-1:0] T_LAST = TW'(TURN_TIMEOUT - 1);
    state_t      st;
    logic [1:0]  last;
    logic [1:0]  turn;
    logic [1:0]  winner;
    logic [3:0]  cmp_idx;
    logic        cmp_start;
    logic        move_start;
    logic        timeout;
    logic        game_over;
    logic [TW-1:0] timer;
    assign bus.state      = st;
    assign bus.turn       = turn;
    assign bus.winner     = winner;
    assign bus.cmp_idx    = cmp_idx;
    assign bus.cmp_start  = cmp_start;
    assign bus.move_start = move_start;
    assign bus.timeout    = timeout;
    assign bus.game_over  = game_over;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st         <= IDLE;
            last       <= 2'd1;
            turn       <= 2'd0;
            winner     <= 2'd0;
            cmp_idx    <= 4'd0;
            cmp_start  <= 1'b0;
            move_start <= 1'b0;
            timeout    <= 1'b0;
            game_over  <= 1'b0;
            timer      <= '0;
        end else begin
            cmp_start  <= 1'b0;
            move_start <= 1'b0;
            timeout    <= 1'b0;
            timer      <= (st == WAIT_FLIP && timer != '1) ? timer + TW'(1) : timer;
            case (st)
                IDLE, OVER: if (bus.start) begin
                    last      <= (bus.num_players == 2'd3) ? 2'd3 : bus.num_players + 2'd1;
                    turn      <= 2'd0;
                    winner    <= 2'd0;
                    game_over <= 1'b0;
                    timer     <= '0;
                    st        <= WAIT_FLIP;
                end
                // a flip in the expiry cycle takes priority over the forfeit
                WAIT_FLIP: if (bus.flip_req) begin
                    cmp_idx   <= bus.flip_idx;
                    cmp_start <= 1'b1;
                    st        <= COMPARE;
                end else if (timer == T_LAST) begin
                    timeout <= 1'b1;
                    st      <= NEXT;
                end
                COMPARE: if (bus.cmp_done) begin
                    move_start <= bus.cmp_match;
                    st         <= bus.cmp_match ? MOVE : NEXT;
                end
                MOVE: if (bus.move_done) begin
                    if (bus.win_det) begin
                        winner    <= turn;
                        game_over <= 1'b1;
                        st        <= OVER;
                    end else begin
                        timer <= '0;
                        st    <= WAIT_FLIP;
                    end
                end
                NEXT: begin
                    turn  <= (turn == last) ? 2'd0 : turn + 2'd1;
                    timer <= '0;
                    st    <= WAIT_FLIP;
                end
                default: st <= IDLE;
            endcase
        end
    end
endmodule
